ts_event_scheduler: RTL and testbench
=====================================

# ts_event_scheduler

Front-end scheduler for the event timestamper. It shares the timestamper's single start port and single end port among `N_REQ` requesters. Each requester asks for a start without naming an ID: the scheduler allocates a free event ID, issues the start, and returns the ID. Later the requester ends that ID, and the scheduler forwards the end, checks ownership, and routes the returned record back to its owner.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (≥2).
- `ID_W`, 4, event ID width; must equal the timestamper's `ID_W`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk` in 1: clock.
  - `rst` in 1: asynchronous, active-high reset.
- Requester start side:
  - `start_req` in N_REQ: level; requester i wants a new event.
  - `start_gnt` out N_REQ: one-hot, 1-cycle pulse; start issued for requester i.
  - `start_gnt_id` out ID_W: ID allocated to the granted requester; valid with `start_gnt`.
- Requester end side:
  - `end_req` in N_REQ: level; requester i wants to end an event.
  - `end_req_id` in N_REQ*ID_W: flattened; slice i is requester i's ID to end.
  - `end_gnt` out N_REQ: one-hot pulse; end accepted by the timestamper.
  - `end_err` out N_REQ: one-hot pulse; end rejected because the ID is not owned by i.
- Timestamper ports:
  - `ts_start_valid` out 1: start request to the timestamper.
  - `ts_start_ready` in 1: timestamper ready for a start.
  - `ts_start_id` out ID_W: ID for the start.
  - `ts_end_valid` out 1: end request to the timestamper.
  - `ts_end_ready` in 1: timestamper ready for an end.
  - `ts_end_id` out ID_W: ID for the end.
  - `ts_out_valid` in 1: timestamper output record valid.
  - `ts_out_id` in ID_W: ID carried by that record.
- Record routing and status:
  - `rec_owner` out N_REQ: one-hot owner of `ts_out_id`; combinational; valid when `ts_out_valid`.
  - `inflight_cnt` out ID_W+1: number of allocated IDs.
  - `ids_full` out 1: no free ID.

## Operation
- State:
  - `busy[2**ID_W]`: per-ID allocation bitmap.
  - `owner[2**ID_W]`: per-ID owner index.
  - Two round-robin pointers, one for start and one for end.
  - Two FSMs, one for start and one for end.
- Start FSM:
  - **S_IDLE.** When any `start_req` is high and `ids_full` is 0, pick the winner round-robin (first requester at or after the pointer). Latch the winner index and the lowest-index free ID, then go to S_ISSUE.
  - **S_ISSUE.** Hold `ts_start_valid`=1 with `ts_start_id` stable until `ts_start_ready` is high. On that handshake: set `busy[id]`, set `owner[id]`=winner, pulse `start_gnt[winner]` with `start_gnt_id`=id, set the pointer to winner+1 (mod N_REQ), and return to S_IDLE.
- End FSM:
  - **E_IDLE.** Pick a round-robin winner among `end_req`. Check that `busy[id]` is set and `owner[id]`==winner.
    - Check fails: pulse `end_err[winner]`, advance the pointer, stay in E_IDLE.
    - Check passes: latch the winner and ID, go to E_ISSUE.
  - **E_ISSUE.** Hold `ts_end_valid`=1 until `ts_end_ready` is high. On that handshake, pulse `end_gnt[winner]`, advance the pointer, and return to E_IDLE.
- Release: when `ts_out_valid` is high, clear `busy[ts_out_id]`. The ID stays owned until its record returns, so `rec_owner` is always a valid lookup.
- `inflight_cnt` is a counter, not a popcount:
  - increment on the start handshake;
  - decrement on release;
  - unchanged when both happen in the same cycle.
- Requesters hold `start_req` and `end_req` until they see their gnt or err pulse. Deasserting a request before then is a protocol violation and leaves behaviour undefined.

## Timing
- Reset values: both FSMs idle; `busy` all 0; pointers 0; `inflight_cnt`=0; `ids_full`=0; every valid, gnt and err output 0; `ts_start_id`, `ts_end_id` and `start_gnt_id` 0.
- Latencies:
  - `start_req` rising to `ts_start_valid`: 1 cycle.
  - `ts_start_ready` handshake to `start_gnt`: same cycle, combinational from the FSM state plus ready.
  - End path: same structure; `end_err` is registered, 1 cycle after the request is sampled.
- Maximum throughput is one start every 2 cycles and one end every 2 cycles. The two paths run independently and concurrently.
- Same-cycle release and allocation: the newly freed ID becomes allocatable the following cycle (no bypass). `ids_full` is registered from the bitmap.
- Start handshake and release hitting the same ID in one cycle is impossible by construction. Add an assertion for it.
- Reset mid-operation drops any pending issue without a gnt pulse and frees all IDs. The timestamper must share `rst`.

## Structure
- Package `ts_pkg`:
  - default constants `TS_ID_W`=4 and `TS_N_REQ`=4;
  - start FSM enum `{S_IDLE, S_ISSUE}`;
  - end FSM enum `{E_IDLE, E_ISSUE}`.
- Sub-module `rr_arbiter #(N)`:
  - inputs: req vector and pointer;
  - outputs: one-hot grant and grant index (combinational);
  - instantiated twice, once per FSM.
- Lowest-free-ID selection is a local priority encoder over `~busy`.

## Test plan
- **Single requester.** Stimulus: after reset, `start_req`=0001, `ts_start_ready`=1. Required: `ts_start_valid` high in cycle 1 with `ts_start_id`=0; `start_gnt`=0001 with `start_gnt_id`=0; `inflight_cnt`=1.
- **Round-robin fairness.** Stimulus: `start_req`=1111 held, ready always 1. Required: grants in order 0001, 0010, 0100, 1000 with IDs 0, 1, 2, 3, one grant every 2 cycles.
- **Exhaustion.** Stimulus: allocate 16 IDs with no records returned. Required: `ids_full`=1, `inflight_cnt`=16, no `ts_start_valid`. Then pulse `ts_out_valid` with `ts_out_id`=5. Required: the next grant returns ID 5.
- **Ownership check.** Stimulus: requester 1 ends ID 0, which is owned by requester 0. Required: `end_err`=0010, no `ts_end_valid`. Stimulus: requester 0 ends ID 0 with `ts_end_ready` low for 3 cycles. Required: `ts_end_valid` held for 3 cycles, then `end_gnt`=0001.
- **Record routing.** Stimulus: `ts_out_valid`=1, `ts_out_id`=2, where requester 2 owns ID 2. Required: `rec_owner`=0100; `busy[2]` cleared the next cycle; `inflight_cnt` decrements, or holds if a start handshake occurs in the same cycle.
- **Reset mid-operation.** Stimulus: assert `rst` while in S_ISSUE. Required: `ts_start_valid` drops asynchronously; no `start_gnt`; all reset values restored.

Source files
------------

// File: rtl/ts_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ts_pkg
// Description : Shared constants and FSM state encodings for the event
//               timestamper front-end scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ts_pkg;

    localparam int TS_ID_W  = 4;
    localparam int TS_N_REQ = 4;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } start_state_t;

    typedef enum logic [0:0] {
        E_IDLE  = 1'b0,
        E_ISSUE = 1'b1
    } end_state_t;

endpackage
`default_nettype wire

// File: rtl/ts_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ts_event_scheduler_if
// Description : Scheduler <-> timestamper link: start/end request channels
//               and the returning record channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface ts_event_scheduler_if
    import ts_pkg::*;
#(
    parameter int ID_W = TS_ID_W
) ();

    logic            ts_start_valid;
    logic            ts_start_ready;
    logic [ID_W-1:0] ts_start_id;
    logic            ts_end_valid;
    logic            ts_end_ready;
    logic [ID_W-1:0] ts_end_id;
    logic            ts_out_valid;
    logic [ID_W-1:0] ts_out_id;

    // Scheduler side
    modport master (
        output ts_start_valid, ts_start_id,
        input  ts_start_ready,
        output ts_end_valid, ts_end_id,
        input  ts_end_ready,
        input  ts_out_valid, ts_out_id
    );

    // Timestamper side
    modport slave (
        input  ts_start_valid, ts_start_id,
        output ts_start_ready,
        input  ts_end_valid, ts_end_id,
        output ts_end_ready,
        output ts_out_valid, ts_out_id
    );

endinterface
`default_nettype wire

// File: rtl/ts_event_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; the first requester at or
//               after the pointer wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] w_pos;

    // Scan from the pointer around the ring and keep the first hit
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = IW'((int'(ptr) + k) % N);
            if (!gnt_vld && req[w_pos]) begin
                gnt_vld    = 1'b1;
                gnt[w_pos] = 1'b1;
                gnt_idx    = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ts_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ts_event_scheduler
// Description : Shares the timestamper start/end ports among N_REQ
//               requesters, allocates event IDs, checks end ownership and
//               routes returned records to their owners.
// Revision    : 1.0 - initial release
// ============================================================================
module ts_event_scheduler
    import ts_pkg::*;
#(
    parameter int N_REQ = TS_N_REQ,
    parameter int ID_W  = TS_ID_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      start_req,
    output logic [N_REQ-1:0]      start_gnt,
    output logic [ID_W-1:0]       start_gnt_id,
    input  logic [N_REQ-1:0]      end_req,
    input  logic [N_REQ*ID_W-1:0] end_req_id,
    output logic [N_REQ-1:0]      end_gnt,
    output logic [N_REQ-1:0]      end_err,
    ts_event_scheduler_if.master  ts,
    output logic [N_REQ-1:0]      rec_owner,
    output logic [ID_W:0]         inflight_cnt,
    output logic                  ids_full
);

    localparam int NUM_ID = 2 ** ID_W;
    localparam int RW     = $clog2(N_REQ);

    logic [NUM_ID-1:0] r_busy, w_busy_nxt;
    logic [RW-1:0]     r_owner [NUM_ID];
    logic [ID_W:0]     r_inflight;
    logic              r_ids_full;
    logic [ID_W-1:0]   w_free_id;

    start_state_t      r_s_state, w_s_state_nxt;
    logic [RW-1:0]     r_s_ptr, r_s_win;
    logic [N_REQ-1:0]  r_s_gnt_oh;
    logic [ID_W-1:0]   r_s_id;
    logic [N_REQ-1:0]  w_s_arb_gnt;
    logic [RW-1:0]     w_s_arb_idx;
    logic              w_s_arb_vld, w_s_load, w_s_hs;

    end_state_t        r_e_state, w_e_state_nxt;
    logic [RW-1:0]     r_e_ptr, r_e_win;
    logic [N_REQ-1:0]  r_e_gnt_oh, r_end_err;
    logic [ID_W-1:0]   r_e_id, w_e_req_id;
    logic [N_REQ-1:0]  w_e_arb_gnt;
    logic [RW-1:0]     w_e_arb_idx;
    logic              w_e_arb_vld, w_e_load, w_e_hs, w_e_reject, w_e_owned;
    logic [ID_W-1:0]   w_end_ids [N_REQ];

    function automatic logic [RW-1:0] f_ptr_next(input logic [RW-1:0] idx);
        return (idx == RW'(N_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_end_ids
            assign w_end_ids[gi] = end_req_id[gi*ID_W +: ID_W];
        end
    endgenerate

    rr_arbiter #(.N(N_REQ), .IW(RW)) u_start_arb (
        .req(start_req), .ptr(r_s_ptr),
        .gnt(w_s_arb_gnt), .gnt_idx(w_s_arb_idx), .gnt_vld(w_s_arb_vld)
    );

    rr_arbiter #(.N(N_REQ), .IW(RW)) u_end_arb (
        .req(end_req), .ptr(r_e_ptr),
        .gnt(w_e_arb_gnt), .gnt_idx(w_e_arb_idx), .gnt_vld(w_e_arb_vld)
    );

    // Lowest-index free ID (priority encoder over ~busy)
    always_comb begin
        w_free_id = '0;
        for (int i = NUM_ID - 1; i >= 0; i--) begin
            if (!r_busy[i]) w_free_id = ID_W'(i);
        end
    end

    // Start FSM: allocate in idle, hold the request until the handshake
    always_comb begin
        w_s_state_nxt     = r_s_state;
        w_s_load          = 1'b0;
        w_s_hs            = 1'b0;
        ts.ts_start_valid = 1'b0;
        start_gnt         = '0;
        case (r_s_state)
            S_IDLE: begin
                if (w_s_arb_vld && !r_ids_full) begin
                    w_s_load      = 1'b1;
                    w_s_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ts.ts_start_valid = 1'b1;
                if (ts.ts_start_ready) begin
                    w_s_hs        = 1'b1;
                    start_gnt     = r_s_gnt_oh;
                    w_s_state_nxt = S_IDLE;
                end
            end
            default: w_s_state_nxt = S_IDLE;
        endcase
    end

    assign ts.ts_start_id = r_s_id;
    assign start_gnt_id   = r_s_id;

    // Start FSM state, winner/ID latch and pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_state  <= S_IDLE;
            r_s_ptr    <= '0;
            r_s_win    <= '0;
            r_s_gnt_oh <= '0;
            r_s_id     <= '0;
        end else begin
            r_s_state <= w_s_state_nxt;
            if (w_s_load) begin
                r_s_win    <= w_s_arb_idx;
                r_s_gnt_oh <= w_s_arb_gnt;
                r_s_id     <= w_free_id;
            end
            if (w_s_hs) r_s_ptr <= f_ptr_next(r_s_win);
        end
    end

    // An end is only forwarded for an allocated ID owned by the requester
    assign w_e_req_id = w_end_ids[w_e_arb_idx];
    assign w_e_owned  = r_busy[w_e_req_id] && (r_owner[w_e_req_id] == w_e_arb_idx);

    // End FSM; the cycle an error pulse is visible is skipped so the
    // rejected requester has time to drop its request
    always_comb begin
        w_e_state_nxt   = r_e_state;
        w_e_load        = 1'b0;
        w_e_hs          = 1'b0;
        w_e_reject      = 1'b0;
        ts.ts_end_valid = 1'b0;
        end_gnt         = '0;
        case (r_e_state)
            E_IDLE: begin
                if (w_e_arb_vld && (r_end_err == '0)) begin
                    if (w_e_owned) begin
                        w_e_load      = 1'b1;
                        w_e_state_nxt = E_ISSUE;
                    end else begin
                        w_e_reject = 1'b1;
                    end
                end
            end
            E_ISSUE: begin
                ts.ts_end_valid = 1'b1;
                if (ts.ts_end_ready) begin
                    w_e_hs        = 1'b1;
                    end_gnt       = r_e_gnt_oh;
                    w_e_state_nxt = E_IDLE;
                end
            end
            default: w_e_state_nxt = E_IDLE;
        endcase
    end

    assign ts.ts_end_id = r_e_id;
    assign end_err      = r_end_err;

    // End FSM state, winner/ID latch, pointer and registered error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_state  <= E_IDLE;
            r_e_ptr    <= '0;
            r_e_win    <= '0;
            r_e_gnt_oh <= '0;
            r_e_id     <= '0;
            r_end_err  <= '0;
        end else begin
            r_e_state <= w_e_state_nxt;
            r_end_err <= w_e_reject ? w_e_arb_gnt : '0;
            if (w_e_load) begin
                r_e_win    <= w_e_arb_idx;
                r_e_gnt_oh <= w_e_arb_gnt;
                r_e_id     <= w_e_req_id;
            end
            if (w_e_reject) r_e_ptr <= f_ptr_next(w_e_arb_idx);
            else if (w_e_hs) r_e_ptr <= f_ptr_next(r_e_win);
        end
    end

    // Next bitmap: set on start handshake, clear on record return
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_s_hs) w_busy_nxt[r_s_id] = 1'b1;
        if (ts.ts_out_valid) w_busy_nxt[ts.ts_out_id] = 1'b0;
    end

    // Allocation bitmap, owner table, in-flight counter and full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_inflight <= '0;
            r_ids_full <= 1'b0;
            for (int i = 0; i < NUM_ID; i++) r_owner[i] <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_ids_full <= &w_busy_nxt;
            if (w_s_hs) r_owner[r_s_id] <= r_s_win;
            case ({w_s_hs, ts.ts_out_valid})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Owner lookup for the returning record
    always_comb begin
        rec_owner = '0;
        if (ts.ts_out_valid) rec_owner[r_owner[ts.ts_out_id]] = 1'b1;
    end

    assign inflight_cnt = r_inflight;
    assign ids_full     = r_ids_full;

    a_no_hs_release_same_id: assert property (@(posedge clk) disable iff (rst)
        !(w_s_hs && ts.ts_out_valid && (ts.ts_out_id == r_s_id)));

endmodule
`default_nettype wire

// File: tb/tb_ts_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ts_event_scheduler
// Description : Directed self-checking bench for ts_event_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_event_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_req, start_gnt, end_req, end_gnt, end_err, rec_owner;
    logic [3:0]  start_gnt_id;
    logic [15:0] end_req_id;
    logic [4:0]  inflight_cnt;
    logic        ids_full;
    int          n_cmp = 0;
    int          n_err = 0;

    ts_event_scheduler_if #(.ID_W(4)) ts_if ();

    ts_event_scheduler #(.N_REQ(4), .ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .start_req(start_req), .start_gnt(start_gnt), .start_gnt_id(start_gnt_id),
        .end_req(end_req), .end_req_id(end_req_id), .end_gnt(end_gnt), .end_err(end_err),
        .ts(ts_if),
        .rec_owner(rec_owner), .inflight_cnt(inflight_cnt), .ids_full(ids_full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_req = '0; end_req = '0; end_req_id = '0;
        ts_if.ts_start_ready = 1'b0; ts_if.ts_end_ready = 1'b0;
        ts_if.ts_out_valid = 1'b0; ts_if.ts_out_id = '0;
        tick(); tick();

        // Reset values
        check("rst_inflight", inflight_cnt, 0);
        check("rst_full", ids_full, 0);
        check("rst_svalid", ts_if.ts_start_valid, 0);
        check("rst_evalid", ts_if.ts_end_valid, 0);
        check("rst_sgnt", start_gnt, 0);
        check("rst_sgnt_id", start_gnt_id, 0);
        check("rst_sid", ts_if.ts_start_id, 0);
        check("rst_eid", ts_if.ts_end_id, 0);
        check("rst_egnt", end_gnt, 0);
        check("rst_eerr", end_err, 0);
        rst = 1'b0;

        // Single requester
        start_req = 4'b0001; ts_if.ts_start_ready = 1'b1; #1;
        check("t1_valid_c0", ts_if.ts_start_valid, 0);
        tick();
        check("t1_valid_c1", ts_if.ts_start_valid, 1);
        check("t1_sid", ts_if.ts_start_id, 0);
        check("t1_gnt", start_gnt, 4'b0001);
        check("t1_gnt_id", start_gnt_id, 0);
        start_req = '0;
        tick();
        check("t1_inflight", inflight_cnt, 1);
        check("t1_gnt_off", start_gnt, 0);

        rst = 1'b1; #1; tick(); rst = 1'b0;

        // Round-robin fairness, all requesters held
        start_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_gnt%0d", k), start_gnt, 32'(1) << k);
            check($sformatf("rr_id%0d", k), start_gnt_id, k);
            tick();
            check($sformatf("rr_gap%0d", k), start_gnt, 0);
        end
        start_req = '0; #1;
        check("rr_inflight", inflight_cnt, 4);

        // Exhaustion: fill the remaining 12 IDs
        start_req = 4'b0001;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("ex_gnt%0d", k), start_gnt, 4'b0001);
            check($sformatf("ex_id%0d", k), start_gnt_id, 4 + k);
            tick();
        end
        check("ex_full", ids_full, 1);
        check("ex_inflight", inflight_cnt, 16);
        tick();
        check("ex_novalid0", ts_if.ts_start_valid, 0);
        tick();
        check("ex_novalid1", ts_if.ts_start_valid, 0);
        ts_if.ts_out_valid = 1'b1; ts_if.ts_out_id = 4'd5; #1;
        check("ex_owner5", rec_owner, 4'b0001);
        tick();
        ts_if.ts_out_valid = 1'b0; #1;
        check("ex_rel_inflight", inflight_cnt, 15);
        check("ex_rel_full", ids_full, 0);
        check("ex_rel_novalid", ts_if.ts_start_valid, 0);
        tick();
        check("ex_re_valid", ts_if.ts_start_valid, 1);
        check("ex_re_gnt", start_gnt, 4'b0001);
        check("ex_re_id", start_gnt_id, 5);
        start_req = '0;
        tick();
        check("ex_re_inflight", inflight_cnt, 16);
        check("ex_re_full", ids_full, 1);

        // Record routing
        ts_if.ts_out_valid = 1'b1; ts_if.ts_out_id = 4'd2; #1;
        check("rt_owner2", rec_owner, 4'b0100);
        tick();
        ts_if.ts_out_valid = 1'b0; #1;
        check("rt_inflight_dec", inflight_cnt, 15);
        start_req = 4'b0010;
        tick();
        ts_if.ts_out_valid = 1'b1; ts_if.ts_out_id = 4'd3; #1;
        check("rt_owner3", rec_owner, 4'b1000);
        check("rt_gnt", start_gnt, 4'b0010);
        check("rt_gnt_id", start_gnt_id, 2);
        tick();
        start_req = '0; ts_if.ts_out_valid = 1'b0; #1;
        check("rt_inflight_hold", inflight_cnt, 15);
        check("rt_full", ids_full, 0);

        // Ownership check: requester 1 ends ID 0 owned by requester 0
        end_req = 4'b0010; end_req_id = 16'h0000; ts_if.ts_end_ready = 1'b0; #1;
        check("own_err_c0", end_err, 0);
        tick();
        check("own_err", end_err, 4'b0010);
        check("own_err_novalid", ts_if.ts_end_valid, 0);
        end_req = '0;
        tick();
        check("own_err_off", end_err, 0);
        check("own_novalid", ts_if.ts_end_valid, 0);
        end_req = 4'b0001;
        tick();
        check("own_valid0", ts_if.ts_end_valid, 1);
        check("own_eid", ts_if.ts_end_id, 0);
        check("own_nognt0", end_gnt, 0);
        tick();
        check("own_valid1", ts_if.ts_end_valid, 1);
        check("own_nognt1", end_gnt, 0);
        tick();
        check("own_valid2", ts_if.ts_end_valid, 1);
        check("own_nognt2", end_gnt, 0);
        ts_if.ts_end_ready = 1'b1; #1;
        check("own_gnt", end_gnt, 4'b0001);
        tick();
        end_req = '0; ts_if.ts_end_ready = 1'b0; #1;
        check("own_done_valid", ts_if.ts_end_valid, 0);
        check("own_done_gnt", end_gnt, 0);

        // Reset while a start is pending
        ts_if.ts_start_ready = 1'b0; start_req = 4'b0001;
        tick();
        check("mr_valid", ts_if.ts_start_valid, 1);
        check("mr_sid", ts_if.ts_start_id, 3);
        rst = 1'b1; ts_if.ts_start_ready = 1'b1; #1;
        check("mr_valid_drop", ts_if.ts_start_valid, 0);
        check("mr_nognt", start_gnt, 0);
        check("mr_inflight", inflight_cnt, 0);
        check("mr_full", ids_full, 0);
        check("mr_gnt_id", start_gnt_id, 0);
        check("mr_sid0", ts_if.ts_start_id, 0);
        start_req = '0;
        tick();
        rst = 1'b0; start_req = 4'b0001;
        tick();
        check("mr_post_gnt", start_gnt, 4'b0001);
        check("mr_post_id", start_gnt_id, 0);
        start_req = '0;
        tick();
        check("mr_post_inflight", inflight_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
